// File: rtl/mont_limb_mult_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mont_limb_mult_seq                                              |
// | Purpose  : Sequencer that forms a wide unsigned product A*B by feeding     |
// |            LIMB_W x LIMB_W limb pairs to an external registered limb       |
// |            multiplier, one pair per cycle, and shift-accumulating the      |
// |            returned 2*LIMB_W-bit partial products into a 2*OPW result.     |
// | Ports    : clk, rst        clock, synchronous active-high reset            |
// |            start, a, b     request and operands (captured on acceptance)   |
// |            busy, done, p   status, one-cycle done pulse, held product      |
// |            mul_d, mul_e    limb operands to the multiplier                 |
// |            mul_f           product returned MUL_LAT cycles later           |
// | Options  : MLS_ZERO_FASTPATH_EN - a zero operand finishes in one cycle     |
// |            without touching the multiplier.                                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mont_limb_mult_seq #(
  parameter int LIMB_W  = 9,
  parameter int NLIMBS  = 4,
  parameter int MUL_LAT = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [LIMB_W*NLIMBS-1:0]     a,
  input  logic [LIMB_W*NLIMBS-1:0]     b,
  output logic                         busy,
  output logic                         done,
  output logic [2*LIMB_W*NLIMBS-1:0]   p,
  output logic [LIMB_W-1:0]            mul_d,
  output logic [LIMB_W-1:0]            mul_e,
  input  logic [2*LIMB_W-1:0]          mul_f
);

  localparam int OPW = LIMB_W * NLIMBS;
  localparam int PW  = 2 * OPW;
  localparam int IW  = (NLIMBS > 1) ? $clog2(NLIMBS) : 1;
  // i+j ranges up to 2*(NLIMBS-1), which always fits in one extra bit.
  localparam int SHW = IW + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NLIMBS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                        state_q, state_d;
  logic [OPW-1:0]                a_q, a_d;
  logic [OPW-1:0]                b_q, b_d;
  logic [PW-1:0]                 acc_q, acc_d;
  logic [PW-1:0]                 p_q, p_d;
  logic [IW-1:0]                 i_q, i_d;
  logic [IW-1:0]                 j_q, j_d;
  logic [MUL_LAT-1:0]            tag_vld_q, tag_vld_d;
  logic [MUL_LAT-1:0][SHW-1:0]   tag_sh_q, tag_sh_d;

  logic                          issue;
  logic                          zero_op;
  logic                          tags_pending;
  logic [PW-1:0]                 f_shifted;

  assign issue = (state_q == ST_ISSUE);
  assign busy  = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign done  = (state_q == ST_DONE);
  assign p     = p_q;

`ifdef MLS_ZERO_FASTPATH_EN
  assign zero_op = (a == '0) || (b == '0);
`else
  assign zero_op = 1'b0;
`endif

  // Limb operands are forced to zero outside ISSUE so the multiplier sees
  // no activity while idle, draining or reporting.
  always_comb begin
    mul_d = '0;
    mul_e = '0;
    if (issue) begin
      mul_d = a_q[int'(i_q)*LIMB_W +: LIMB_W];
      mul_e = b_q[int'(j_q)*LIMB_W +: LIMB_W];
    end
  end

  // Tag pipe runs in lock-step with the multiplier: the last stage carries
  // the shift for whatever product is on mul_f in the current cycle.
  always_comb begin
    tag_vld_d    = '0;
    tag_sh_d     = '0;
    tag_vld_d[0] = issue;
    tag_sh_d[0]  = SHW'(i_q) + SHW'(j_q);
    for (int k = 1; k < MUL_LAT; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_sh_d[k]  = tag_sh_q[k-1];
    end
  end

  // Products still in flight excluding the one consumed this cycle. When
  // this is clear in DRAIN, the final accumulate happens at this edge and
  // DONE can follow immediately.
  always_comb begin
    tags_pending = 1'b0;
    for (int k = 0; k < MUL_LAT - 1; k++) begin
      tags_pending = tags_pending | tag_vld_q[k];
    end
  end

  always_comb begin
    f_shifted = {{(PW-2*LIMB_W){1'b0}}, mul_f} << (int'(tag_sh_q[MUL_LAT-1]) * LIMB_W);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    i_d     = i_q;
    j_d     = j_q;
    p_d     = p_q;
    acc_d   = tag_vld_q[MUL_LAT-1] ? (acc_q + f_shifted) : acc_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = zero_op ? ST_DONE : ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // j is the inner index; pair (N-1,N-1) is the last issue.
        if (j_q == LAST_IDX) begin
          j_d = '0;
          if (i_q == LAST_IDX) begin
            state_d = ST_DRAIN;
          end else begin
            i_d = i_q + IW'(1);
          end
        end else begin
          j_d = j_q + IW'(1);
        end
      end
      ST_DRAIN: begin
        if (!tags_pending) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // p is loaded with the completed sum on entry to DONE and then held.
    if (state_d == ST_DONE) begin
      p_d = acc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      p_q       <= '0;
      i_q       <= '0;
      j_q       <= '0;
      tag_vld_q <= '0;
      tag_sh_q  <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      p_q       <= p_d;
      i_q       <= i_d;
      j_q       <= j_d;
      tag_vld_q <= tag_vld_d;
      tag_sh_q  <= tag_sh_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mont_limb_mult_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mont_limb_mult_seq                                           |
// | Purpose  : Self-checking bench for mont_limb_mult_seq with a behavioural   |
// |            two-stage limb multiplier and a queue-based scoreboard.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mont_limb_mult_seq;

  localparam int LIMB_W  = 9;
  localparam int NLIMBS  = 4;
  localparam int MUL_LAT = 2;
  localparam int OPW     = LIMB_W * NLIMBS;
  localparam int PW      = 2 * OPW;
  localparam int LAT     = NLIMBS * NLIMBS + MUL_LAT + 1;
`ifdef MLS_ZERO_FASTPATH_EN
  localparam int ZLAT    = 1;
`else
  localparam int ZLAT    = LAT;
`endif
  localparam int NRAND   = 500;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [OPW-1:0]    a;
  logic [OPW-1:0]    b;
  logic              busy;
  logic              done;
  logic [PW-1:0]     p;
  logic [LIMB_W-1:0] mul_d;
  logic [LIMB_W-1:0] mul_e;
  logic [2*LIMB_W-1:0] mul_f = '0;
  logic [2*LIMB_W-1:0] m1    = '0;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [PW-1:0] p;
    int            id;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  logic [OPW-1:0] ra[NRAND];
  logic [OPW-1:0] rb[NRAND];

  mont_limb_mult_seq #(
    .LIMB_W  (LIMB_W),
    .NLIMBS  (NLIMBS),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p),
    .mul_d (mul_d),
    .mul_e (mul_e),
    .mul_f (mul_f)
  );

  always #5 clk = ~clk;

  // Registered limb multiplier: product visible two cycles after the operands.
  always @(posedge clk) begin
    m1    <= mul_d * mul_e;
    mul_f <= m1;
  end

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] ref_mul(input logic [OPW-1:0] x, input logic [OPW-1:0] y);
    logic [PW-1:0] xe;
    logic [PW-1:0] ye;
    xe = {{OPW{1'b0}}, x};
    ye = {{OPW{1'b0}}, y};
    return xe * ye;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: done=1 with nothing pending, p=%h", p);
      end else begin
        mon_e = sb_q.pop_front();
        check($sformatf("product_id%0d", mon_e.id), p, mon_e.p);
      end
    end
  end

  // One operation from idle with cycle-by-cycle busy/done checks.
  // gk>0 pulses a second start (with other operands) in cycle T+gk.
  task automatic run_op(input logic [OPW-1:0] av, input logic [OPW-1:0] bv,
                        input logic [PW-1:0] expv, input int id, input int lat,
                        input int gk, input bit chk_zero);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    sb_q.push_back('{expv, id});
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      start = 1'b0;
      a = ~av; b = ~bv;
      check($sformatf("id%0d_done_T%0d", id, k), PW'(done), PW'(k == lat));
      check($sformatf("id%0d_busy_T%0d", id, k), PW'(busy), PW'(k < lat));
      if (k == 1 && lat == LAT) begin
        check($sformatf("id%0d_mul_d_first", id), PW'(mul_d), PW'(av[LIMB_W-1:0]));
        check($sformatf("id%0d_mul_e_first", id), PW'(mul_e), PW'(bv[LIMB_W-1:0]));
      end
      if (chk_zero || k == lat) begin
        check($sformatf("id%0d_mul_idle_T%0d", id, k), PW'({mul_d, mul_e}), '0);
      end
      if (k == gk) begin
        start = 1'b1;
        a = 36'h5_5555_5555; b = 36'h0_0000_0007;
      end
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [63:0] t64;
    int k;
    int guard;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    for (int i = 0; i < NRAND; i++) begin
      t64 = {$urandom(), $urandom()};
      ra[i] = t64[OPW-1:0];
      t64 = {$urandom(), $urandom()};
      rb[i] = t64[OPW-1:0];
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", PW'(busy), '0);
    check("rst_done", PW'(done), '0);
    check("rst_p", p, '0);
    check("rst_mul", PW'({mul_d, mul_e}), '0);
    rst = 1'b0;

    // 1: unit operands
    run_op(36'h1, 36'h1, 72'h1, 1, LAT, 0, 1'b0);
    // 2: all-ones operands
    run_op(36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF, 72'hFF_FFFF_FFE0_0000_0001, 2, LAT, 0, 1'b0);
    // 3: start re-pulsed while busy must be ignored
    run_op(36'h1_2345_6789, 36'h9_8765_4321,
           ref_mul(36'h1_2345_6789, 36'h9_8765_4321), 3, LAT, 5, 1'b0);
    check("held_p_after_done", p, ref_mul(36'h1_2345_6789, 36'h9_8765_4321));

    // 4: reset in cycle T+8 aborts the operation
    @(negedge clk);
    a = 36'hF_FFFF_FFFF; b = 36'hA_BCDE_F012; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check("abort_busy", PW'(busy), '0);
    check("abort_p", p, '0);
    check("abort_done", PW'(done), '0);
    rst = 1'b0;
    for (int i = 0; i < LAT + 6; i++) begin
      @(negedge clk);
      check($sformatf("abort_no_done_%0d", i), PW'(done), '0);
    end
    run_op(36'd3, 36'd5, 72'd15, 4, LAT, 0, 1'b0);

    // 5: zero operand
    run_op(36'd0, 36'd5, 72'd0, 5, ZLAT, 0, ZLAT == 1);

    // 6: back-to-back with start held through DONE
    @(negedge clk);
    a = ra[0]; b = rb[0]; start = 1'b1;
    sb_q.push_back('{ref_mul(ra[0], rb[0]), 1000});
    for (int n = 1; n <= NRAND; n++) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (done !== 1'b1 && k < LAT + 5);
      check($sformatf("b2b_latency_%0d", n), PW'(k), PW'(LAT));
      if (n < NRAND) begin
        a = ra[n]; b = rb[n];
        sb_q.push_back('{ref_mul(ra[n], rb[n]), 1000 + n});
      end else begin
        start = 1'b0;
      end
    end

    guard = 0;
    while (sb_q.size() != 0 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d results still pending, required 0", sb_q.size());
    end
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
